// File: rtl/ulpcluster_iso_pkg.sv
// Shared types and helpers for the cluster async-port
// drain-and-isolate controller.
package ulpcluster_iso_pkg;

   localparam int ISO_STATE_W = 3;
   localparam int TOKEN_W_MAX = 32;

   typedef enum logic [ISO_STATE_W-1:0] {
      RUN     = 3'd0,
      DRAIN   = 3'd1,
      ISO     = 3'd2,
      RELEASE = 3'd3
   } iso_state_e;

   // Tokens are one-hot rings, so empty is plain equality.
   function automatic logic onehot_eq(
      input logic [TOKEN_W_MAX-1:0] a,
      input logic [TOKEN_W_MAX-1:0] b
   );
      return (a == b);
   endfunction

endpackage

// File: rtl/ulpcluster_token_sync.sv
// Generic WIDTH x STAGES flop synchroniser,
// asynchronous active-high reset to zero.
module ulpcluster_token_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ulpcluster_axi_async_iso_ctrl.sv
// Drain-and-isolate controller for cluster async token/pointer ports.
// Optional forced isolation on drain timeout: ISO_DRAIN_TIMEOUT_EN.
module ulpcluster_axi_async_iso_ctrl
   import ulpcluster_iso_pkg::*;
#(
   parameter int NUM_CH         = 5,
   parameter int BUFFER_WIDTH   = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 4,
   parameter int RELEASE_CYCLES = 16,
   parameter int DRAIN_TIMEOUT  = 1024,
   parameter int RESET_ISOLATED = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           iso_req_i,
   input  logic [NUM_CH*BUFFER_WIDTH-1:0] wr_token_i,
   input  logic [NUM_CH*BUFFER_WIDTH-1:0] rd_ptr_i,
   output logic                           stall_o,
   output logic                           iso_en_o,
   output logic                           iso_ack_o,
   output logic [NUM_CH-1:0]              ch_empty_o,
   output logic [ISO_STATE_W-1:0]         state_o,
   output logic                           timeout_o
);

   localparam int BW  = BUFFER_WIDTH;
   localparam int TW  = NUM_CH * BW;
   localparam int SCW = $clog2(STABLE_CYCLES + 1);
   localparam int RCW = $clog2(RELEASE_CYCLES + 1);
   localparam logic RST_CLAMP = (RESET_ISOLATED != 0);
   localparam iso_state_e RST_STATE =
      (RESET_ISOLATED != 0) ? ISO : RUN;

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1 || RELEASE_CYCLES < 1) begin : g_chk_cnt
      $error("STABLE_CYCLES and RELEASE_CYCLES must be >= 1");
   end
   if (DRAIN_TIMEOUT < 1 || BW > TOKEN_W_MAX) begin : g_chk_misc
      $error("bad DRAIN_TIMEOUT or BUFFER_WIDTH");
   end

   logic [2*TW-1:0] tok_sync;
   logic [TW-1:0]   wr_sync;
   logic [TW-1:0]   rd_sync;

   ulpcluster_token_sync #(
      .WIDTH  (2 * TW),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   ({rd_ptr_i, wr_token_i}),
      .q_o   (tok_sync)
   );

   assign {rd_sync, wr_sync} = tok_sync;

   iso_state_e       state_q, state_d;
   logic             stall_q, stall_d;
   logic             iso_en_q, iso_en_d;
   logic             ack_q, ack_d;
   logic [NUM_CH-1:0] ch_empty_q, ch_empty_d;
   logic [SCW-1:0]   stable_cnt_q, stable_cnt_d;
   logic [RCW-1:0]   rel_cnt_q, rel_cnt_d;
   logic             all_empty;
   logic             stable_done;
   logic             drain_expired;

   always_comb begin
      ch_empty_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_empty_d[c] = onehot_eq(
            TOKEN_W_MAX'(wr_sync[c*BW +: BW]),
            TOKEN_W_MAX'(rd_sync[c*BW +: BW]));
      end
   end

   assign all_empty   = &ch_empty_q;
   assign stable_done = (stable_cnt_q == SCW'(STABLE_CYCLES));

`ifdef ISO_DRAIN_TIMEOUT_EN
   localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

   logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
   logic           timeout_q, timeout_d;
   logic           force_iso;

   assign drain_expired =
      (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1));
   // Timeout only counts when the normal exits did not fire.
   assign force_iso = (state_q == DRAIN) && iso_req_i &&
                      !stable_done && drain_expired;

   always_comb begin
      drain_cnt_d = '0;
      timeout_d   = timeout_q;
      if (state_q == DRAIN && !drain_expired) begin
         drain_cnt_d = drain_cnt_q + DCW'(1);
      end
      if (state_d == RUN) begin
         timeout_d = 1'b0;
      end else if (force_iso) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign drain_expired = 1'b0;
   assign timeout_o     = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      rel_cnt_d    = rel_cnt_q;
      stable_cnt_d = stable_cnt_q;
      if (state_q == RUN || !all_empty) begin
         stable_cnt_d = '0;
      end else if (!stable_done) begin
         stable_cnt_d = stable_cnt_q + SCW'(1);
      end
      case (state_q)
         RUN: begin
            if (iso_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            // Abort has priority over a completing drain.
            if (!iso_req_i)         state_d = RUN;
            else if (stable_done)   state_d = ISO;
            else if (drain_expired) state_d = ISO;
         end
         ISO: begin
            if (!iso_req_i) begin
               state_d   = RELEASE;
               rel_cnt_d = RCW'(RELEASE_CYCLES - 1);
            end
         end
         RELEASE: begin
            if (iso_req_i) begin
               state_d = DRAIN;
            end else if (rel_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               rel_cnt_d = rel_cnt_q - RCW'(1);
            end
         end
         default: state_d = RST_STATE;
      endcase
      stall_d  = (state_d != RUN);
      iso_en_d = (state_d == ISO);
      ack_d    = (state_d == ISO);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RST_STATE;
         stall_q      <= RST_CLAMP;
         iso_en_q     <= RST_CLAMP;
         ack_q        <= RST_CLAMP;
         ch_empty_q   <= '1;
         stable_cnt_q <= '0;
         rel_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         stall_q      <= stall_d;
         iso_en_q     <= iso_en_d;
         ack_q        <= ack_d;
         ch_empty_q   <= ch_empty_d;
         stable_cnt_q <= stable_cnt_d;
         rel_cnt_q    <= rel_cnt_d;
      end
   end

   assign stall_o    = stall_q;
   assign iso_en_o   = iso_en_q;
   assign iso_ack_o  = ack_q;
   assign ch_empty_o = ch_empty_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_ulpcluster_axi_async_iso_ctrl.sv
// Directed bench for the async-port isolation controller,
// covering both reset flavours and the optional drain timeout.
module tb_ulpcluster_axi_async_iso_ctrl;

   localparam int NUM_CH = 5;
   localparam int BW     = 8;
   localparam int TW     = NUM_CH * BW;

   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic          iso_req = 1'b0;
   logic [TW-1:0] wr_tok  = '0;
   logic [TW-1:0] rd_ptr  = '0;

   logic              a_stall, a_iso_en, a_ack, a_timeout;
   logic [NUM_CH-1:0] a_empty;
   logic [2:0]        a_state;
   logic              b_stall, b_iso_en, b_ack, b_timeout;
   logic [NUM_CH-1:0] b_empty;
   logic [2:0]        b_state;
   logic [3:0]        a_ctl, b_ctl;

   assign a_ctl = {a_stall, a_iso_en, a_ack, a_timeout};
   assign b_ctl = {b_stall, b_iso_en, b_ack, b_timeout};

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   ulpcluster_axi_async_iso_ctrl #(
      .DRAIN_TIMEOUT  (32),
      .RESET_ISOLATED (1)
   ) u_dut_a (
      .clk_i      (clk),
      .rst_i      (rst),
      .iso_req_i  (iso_req),
      .wr_token_i (wr_tok),
      .rd_ptr_i   (rd_ptr),
      .stall_o    (a_stall),
      .iso_en_o   (a_iso_en),
      .iso_ack_o  (a_ack),
      .ch_empty_o (a_empty),
      .state_o    (a_state),
      .timeout_o  (a_timeout)
   );

   ulpcluster_axi_async_iso_ctrl #(
      .DRAIN_TIMEOUT  (32),
      .RESET_ISOLATED (0)
   ) u_dut_b (
      .clk_i      (clk),
      .rst_i      (rst),
      .iso_req_i  (iso_req),
      .wr_token_i (wr_tok),
      .rd_ptr_i   (rd_ptr),
      .stall_o    (b_stall),
      .iso_en_o   (b_iso_en),
      .iso_ack_o  (b_ack),
      .ch_empty_o (b_empty),
      .state_o    (b_state),
      .timeout_o  (b_timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         e.tag = "scoreboard_empty";
         e.v   = 'x;
      end else begin
         e = sb.pop_front();
      end
      assert (obs === e.v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                e.tag, obs, e.v);
      end
   endtask

   task automatic set_ch(input int c, input logic [7:0] w,
                         input logic [7:0] r);
      wr_tok[c*BW +: BW] = w;
      rd_ptr[c*BW +: BW] = r;
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (a_state !== 3'd0 && n < 60) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int   n;
      logic seen;

      for (int c = 0; c < NUM_CH; c++) set_ch(c, 8'h01, 8'h01);
      #1 rst = 1'b1;
      tick();
      tick();
      push("rst_a_state", 32'd2);      chk(a_state);
      push("rst_a_ctl", 32'b1110);     chk(a_ctl);
      push("rst_a_empty", 32'h1f);     chk(a_empty);
      push("rst_b_state", 32'd0);      chk(b_state);
      push("rst_b_ctl", 32'b0000);     chk(b_ctl);
      push("rst_b_empty", 32'h1f);     chk(b_empty);

      rst = 1'b0;
      tick();
      push("t1_rel_state", 32'd3);     chk(a_state);
      push("t1_rel_ctl", 32'b1000);    chk(a_ctl);
      n    = 0;
      seen = 1'b0;
      while (a_state !== 3'd0 && n < 60) begin
         tick();
         n++;
         seen |= a_iso_en | a_ack;
      end
      push("t1_rel_len", 32'd16);      chk(n);
      push("t1_rel_clamp", 32'd0);     chk(seen);
      push("t1_run_ctl", 32'b0000);    chk(a_ctl);

      iso_req = 1'b1;
      tick();
      push("t2_drain_state", 32'd1);   chk(a_state);
      push("t2_stall", 32'b1000);      chk(a_ctl);
      n = 0;
      while (!a_iso_en && n < 30) begin
         tick();
         n++;
      end
      push("t2_iso_lat", 32'd5);       chk(n);
      push("t2_iso_ctl", 32'b1110);    chk(a_ctl);
      push("t2_iso_state", 32'd2);     chk(a_state);

      iso_req = 1'b0;
      wait_run(n);
      push("t3_back_run", 32'd17);     chk(n);
      set_ch(3, 8'h04, 8'h02);
      repeat (5) tick();
      push("t3_empty", 32'b10111);     chk(a_empty);
      iso_req = 1'b1;
      repeat (11) tick();
      push("t3_hold_state", 32'd1);    chk(a_state);
      push("t3_hold_ctl", 32'b1000);   chk(a_ctl);
      rd_ptr[3*BW +: BW] = 8'h04;
      repeat (3) tick();
      push("t3_mid_state", 32'd1);     chk(a_state);
      rd_ptr[3*BW +: BW] = 8'h02;
      tick();
      rd_ptr[3*BW +: BW] = 8'h04;
      n = 1;
      while (!a_iso_en && n < 30) begin
         tick();
         n++;
      end
      push("t3_restart_lat", 32'd9);   chk(n);

      iso_req = 1'b0;
      wait_run(n);
      iso_req = 1'b1;
      tick();
      seen = a_iso_en;
      repeat (4) begin
         tick();
         seen |= a_iso_en;
      end
      iso_req = 1'b0;
      tick();
      seen |= a_iso_en;
      push("t4_abort_state", 32'd0);   chk(a_state);
      push("t4_no_clamp", 32'd0);      chk(seen);
      push("t4_ctl", 32'b0000);        chk(a_ctl);

      set_ch(0, 8'h04, 8'h02);
      repeat (5) tick();
      push("t5_empty", 32'b11110);     chk(a_empty);
      iso_req = 1'b1;
      tick();
      n = 0;
      while (!a_iso_en && n < 40) begin
         tick();
         n++;
      end
`ifdef ISO_DRAIN_TIMEOUT_EN
      push("t5_to_lat", 32'd32);       chk(n);
      push("t5_to_ctl", 32'b1111);     chk(a_ctl);
      iso_req = 1'b0;
      tick();
      push("t5_rel_ctl", 32'b1001);    chk(a_ctl);
      wait_run(n);
      push("t5_run_ctl", 32'b0000);    chk(a_ctl);
`else
      push("t5_wait", 32'd40);         chk(n);
      push("t5_wait_state", 32'd1);    chk(a_state);
      push("t5_wait_ctl", 32'b1000);   chk(a_ctl);
      iso_req = 1'b0;
      tick();
      push("t5_abort_state", 32'd0);   chk(a_state);
`endif

      iso_req = 1'b1;
      repeat (3) tick();
      push("t6_b_state", 32'd1);       chk(b_state);
      push("t6_b_ctl", 32'b1000);      chk(b_ctl);
      push("t6_b_empty", 32'b11110);   chk(b_empty);
      rst = 1'b1;
      #2;
      push("t6_rst_b_state", 32'd0);   chk(b_state);
      push("t6_rst_b_ctl", 32'b0000);  chk(b_ctl);
      push("t6_rst_b_empty", 32'h1f);  chk(b_empty);
      push("t6_rst_a_state", 32'd2);   chk(a_state);
      push("t6_rst_a_ctl", 32'b1110);  chk(a_ctl);
      tick();
      iso_req = 1'b0;
      rst     = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
